// File: rtl/msix_vector_table_if.sv
// Register-bus and message-descriptor signals of the MSI-X table block.
// The slave modport is the table; the master modport is the decoder/TLP side.
interface msix_vector_table_if #(
    parameter int NUM_VECTORS = 8
);
    localparam int PBA_DW = (NUM_VECTORS + 31) / 32;
    localparam int AW     = $clog2(4 * NUM_VECTORS + PBA_DW);

    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic [3:0]    reg_be;
    logic [31:0]   reg_rdata;
    logic          reg_rd_valid;
    logic          msg_valid;
    logic          msg_ready;
    logic [63:0]   msg_addr;
    logic [31:0]   msg_data;
    logic [7:0]    msg_vector;

    modport slave (
        input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata, reg_be, msg_ready,
        output reg_rdata, reg_rd_valid, msg_valid, msg_addr, msg_data, msg_vector
    );

    modport master (
        output reg_wr_en, reg_rd_en, reg_addr, reg_wdata, reg_be, msg_ready,
        input  reg_rdata, reg_rd_valid, msg_valid, msg_addr, msg_data, msg_vector
    );
endinterface

// File: rtl/msix_vector_table.sv
// MSI-X table + Pending Bit Array backend: latches interrupt requests and emits
// one memory-write descriptor per eligible vector, round-robin, over valid/ready.
module msix_vector_table #(
    parameter int NUM_VECTORS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   msix_enable,
    input  logic                   func_mask,
    input  logic [NUM_VECTORS-1:0] irq_req,
    msix_vector_table_if.slave     bus
);
    localparam int PBA_DW = (NUM_VECTORS + 31) / 32;
    localparam int AW     = $clog2(4 * NUM_VECTORS + PBA_DW);
    localparam int IDXW   = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [31:0]            addr_lo [NUM_VECTORS];
    logic [31:0]            addr_hi [NUM_VECTORS];
    logic [31:0]            data_q  [NUM_VECTORS];
    logic [NUM_VECTORS-1:0] mask;
    logic [NUM_VECTORS-1:0] pending;
    logic [NUM_VECTORS-1:0] eligible;
    logic [NUM_VECTORS-1:0] clr_pending;
    logic [PBA_DW*32-1:0]   pba_flat;
    logic [AW-3:0]          entry;
    logic [1:0]             word;
    logic [31:0]            rd_next;
    logic [31:0]            rdata_q;
    logic                   rd_valid_q;
    logic [0:0]             state;
    logic [IDXW-1:0]        last_vec;
    logic [IDXW-1:0]        sel_idx;
    logic                   sel_found;
    logic                   handshake;
    logic [63:0]            msg_addr_q;
    logic [31:0]            msg_data_q;
    logic [7:0]             msg_vec_q;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    assign entry       = bus.reg_addr[AW-1:2];
    assign word        = bus.reg_addr[1:0];
    assign eligible    = pending & ~mask & {NUM_VECTORS{msix_enable & ~func_mask}};
    assign handshake   = (state == S_SEND) && bus.msg_ready;
    assign clr_pending = handshake ? (NUM_VECTORS'(1) << msg_vec_q) : '0;
    assign pba_flat    = (PBA_DW*32)'(pending);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_VECTORS; k++) begin
            if (entry == (AW-2)'(k)) begin
                case (word)
                    2'd0:    rd_next = addr_lo[k];
                    2'd1:    rd_next = addr_hi[k];
                    2'd2:    rd_next = data_q[k];
                    default: rd_next = {31'b0, mask[k]};
                endcase
            end
        end
        for (int j = 0; j < PBA_DW; j++)
            if (bus.reg_addr == AW'(4 * NUM_VECTORS + j))
                rd_next = pba_flat[32*j +: 32];
    end

    // Round-robin: scan starting one past the last vector that completed a handshake.
    always_comb begin : rr_pick
        int c;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= NUM_VECTORS; i++) begin
            c = int'(last_vec) + i;
            if (c >= NUM_VECTORS) c = c - NUM_VECTORS;
            if (!sel_found && eligible[c]) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(c);
            end
        end
    end

    // NOTE: the table is small and must come up with defined contents, so every entry is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_VECTORS; k++) begin
                addr_lo[k] <= '0;
                addr_hi[k] <= '0;
                data_q[k]  <= '0;
            end
            mask <= '1;
        end else if (bus.reg_wr_en) begin
            for (int k = 0; k < NUM_VECTORS; k++) begin
                if (entry == (AW-2)'(k)) begin
                    case (word)
                        2'd0: addr_lo[k] <= be_merge(addr_lo[k], bus.reg_wdata, bus.reg_be)
                                            & 32'hFFFF_FFFC;
                        2'd1: addr_hi[k] <= be_merge(addr_hi[k], bus.reg_wdata, bus.reg_be);
                        2'd2: data_q[k]  <= be_merge(data_q[k], bus.reg_wdata, bus.reg_be);
                        default: if (bus.reg_be[0]) mask[k] <= bus.reg_wdata[0];
                    endcase
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            // A request landing on the handshake cycle is a new event and survives the clear.
            pending    <= (pending & ~clr_pending) | irq_req;
            rd_valid_q <= bus.reg_rd_en;
            if (bus.reg_rd_en) rdata_q <= rd_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_vec   <= IDXW'(NUM_VECTORS - 1);
            msg_addr_q <= '0;
            msg_data_q <= '0;
            msg_vec_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (sel_found) begin
                    msg_addr_q <= {addr_hi[sel_idx], addr_lo[sel_idx]};
                    msg_data_q <= data_q[sel_idx];
                    msg_vec_q  <= 8'(sel_idx);
                    state      <= S_SEND;
                end
                default: if (bus.msg_ready) begin
                    last_vec <= msg_vec_q[IDXW-1:0];
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.reg_rdata    = rdata_q;
    assign bus.reg_rd_valid = rd_valid_q;
    assign bus.msg_valid    = (state == S_SEND);
    assign bus.msg_addr     = msg_addr_q;
    assign bus.msg_data     = msg_data_q;
    assign bus.msg_vector   = msg_vec_q;
endmodule

// File: tb/tb_msix_vector_table.sv
// Directed bench for msix_vector_table with a transaction-level model checked every cycle.
module tb_msix_vector_table;
    localparam int N  = 8;
    localparam int AW = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         msix_enable;
    logic         func_mask;
    logic [N-1:0] irq_req;

    msix_vector_table_if #(.NUM_VECTORS(N)) bus ();

    msix_vector_table #(.NUM_VECTORS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .msix_enable (msix_enable),
        .func_mask   (func_mask),
        .irq_req     (irq_req),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model state: what the table must hold and what the outputs must show.
    logic [31:0] m_lo [N];
    logic [31:0] m_hi [N];
    logic [31:0] m_dat [N];
    logic [N-1:0] m_mask, m_pend;
    bit          m_busy, m_rdv;
    int          m_last;
    logic [7:0]  m_vec;
    logic [63:0] m_addr;
    logic [31:0] m_data, m_rdata;

    logic [7:0]  log_vec [$];
    logic [63:0] log_addr [$];
    logic [31:0] log_data [$];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a < 4 * N) begin
            case (a % 4)
                0: return m_lo[a/4];
                1: return m_hi[a/4];
                2: return m_dat[a/4];
                default: return {31'b0, m_mask[a/4]};
            endcase
        end
        if (a == 4 * N) return {{(32-N){1'b0}}, m_pend};
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_lo[k] = '0; m_hi[k] = '0; m_dat[k] = '0;
        end
        m_mask = '1; m_pend = '0; m_busy = 0; m_rdv = 0; m_last = N - 1;
        m_vec = '0; m_addr = '0; m_data = '0; m_rdata = '0;
    endtask

    // Compare, then advance the model across the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        else begin
            logic [N-1:0] npend;
            bit nb;
            int a, k;
            check("msg_valid", {63'b0, bus.msg_valid}, {63'b0, m_busy});
            if (m_busy) begin
                check("msg_addr", bus.msg_addr, m_addr);
                check("msg_data", {32'b0, bus.msg_data}, {32'b0, m_data});
                check("msg_vector", {56'b0, bus.msg_vector}, {56'b0, m_vec});
            end
            check("rd_valid", {63'b0, bus.reg_rd_valid}, {63'b0, m_rdv});
            if (m_rdv) check("rdata", {32'b0, bus.reg_rdata}, {32'b0, m_rdata});
            if (bus.msg_valid && bus.msg_ready) begin
                log_vec.push_back(bus.msg_vector);
                log_addr.push_back(bus.msg_addr);
                log_data.push_back(bus.msg_data);
            end
            npend = m_pend;
            nb    = m_busy;
            if (m_busy && bus.msg_ready) begin
                npend[m_vec] = 1'b0;
                m_last = int'(m_vec);
                nb = 0;
            end else if (!m_busy && msix_enable && !func_mask) begin
                for (int i = 1; i <= N; i++) begin
                    k = (m_last + i) % N;
                    if (!nb && m_pend[k] && !m_mask[k]) begin
                        nb = 1;
                        m_vec = 8'(k);
                        m_addr = {m_hi[k], m_lo[k]};
                        m_data = m_dat[k];
                    end
                end
            end
            npend = npend | irq_req;
            a = int'(bus.reg_addr);
            m_rdv = bus.reg_rd_en;
            if (bus.reg_rd_en) m_rdata = model_read(a);
            if (bus.reg_wr_en && a < 4 * N) begin
                case (a % 4)
                    0: m_lo[a/4]  = merge(m_lo[a/4], bus.reg_wdata, bus.reg_be) & 32'hFFFF_FFFC;
                    1: m_hi[a/4]  = merge(m_hi[a/4], bus.reg_wdata, bus.reg_be);
                    2: m_dat[a/4] = merge(m_dat[a/4], bus.reg_wdata, bus.reg_be);
                    default: if (bus.reg_be[0]) m_mask[a/4] = bus.reg_wdata[0];
                endcase
            end
            m_pend = npend;
            m_busy = nb;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        bus.reg_wr_en = 1'b1; bus.reg_addr = a[AW-1:0]; bus.reg_wdata = d; bus.reg_be = be;
        tick();
        bus.reg_wr_en = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        bus.reg_rd_en = 1'b1; bus.reg_addr = a[AW-1:0];
        tick();
        bus.reg_rd_en = 1'b0;
        d = bus.reg_rdata;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        irq_req = v;
        tick();
        irq_req = '0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.msg_valid) begin ok = 1; return; end
            tick();
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [63:0] h_addr;
        logic [31:0] h_data;
        logic [7:0]  h_vec;
        bit ok;

        rst_n = 1'b0; msix_enable = 1'b1; func_mask = 1'b0; irq_req = '0;
        bus.reg_wr_en = 1'b0; bus.reg_rd_en = 1'b0; bus.reg_addr = '0;
        bus.reg_wdata = '0; bus.reg_be = '0; bus.msg_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_msg_valid", {63'b0, bus.msg_valid}, 64'h0);
        check("rst_msg_addr", bus.msg_addr, 64'h0);
        check("rst_rd_valid", {63'b0, bus.reg_rd_valid}, 64'h0);
        check("rst_rdata", {32'b0, bus.reg_rdata}, 64'h0);
        rst_n = 1'b1;
        tick();

        rd(3, d);  check("rst_vctrl3", {32'b0, d}, 64'h1);
        rd(32, d); check("rst_pba", {32'b0, d}, 64'h0);

        wr(8, 32'hFEE0_0003, 4'hF);
        wr(9, 32'h0000_0001, 4'hF);
        wr(10, 32'hABCD_0042, 4'hF);
        wr(11, 32'h0, 4'hF);
        pulse(8'h04);
        repeat (5) tick();
        check("v2_count", 64'(log_vec.size()), 64'd1);
        check("v2_vec", {56'b0, log_vec[0]}, 64'd2);
        check("v2_addr", log_addr[0], 64'h1_FEE0_0000);
        check("v2_data", {32'b0, log_data[0]}, 64'hABCD_0042);
        rd(32, d); check("v2_pba", {32'b0, d}, 64'h0);

        pulse(8'h20);
        repeat (4) tick();
        rd(32, d); check("v5_masked_pba", {32'b0, d}, 64'h20);
        check("v5_masked_count", 64'(log_vec.size()), 64'd1);
        wr(23, 32'h0, 4'hF);
        repeat (5) tick();
        check("v5_count", 64'(log_vec.size()), 64'd2);
        check("v5_vec", {56'b0, log_vec[1]}, 64'd5);
        rd(32, d); check("v5_pba", {32'b0, d}, 64'h0);

        wr(2, 32'h1122_3344, 4'hF);
        wr(2, 32'h0000_5500, 4'h2);
        rd(2, d); check("partial_be", {32'b0, d}, 64'h1122_5544);
        bus.reg_wr_en = 1'b1; bus.reg_rd_en = 1'b1; bus.reg_addr = 6'd2;
        bus.reg_wdata = 32'h5566_7788; bus.reg_be = 4'hF;
        tick();
        bus.reg_wr_en = 1'b0; bus.reg_rd_en = 1'b0;
        check("rw_same_old", {32'b0, bus.reg_rdata}, 64'h1122_5544);
        rd(2, d); check("rw_same_new", {32'b0, d}, 64'h5566_7788);

        wr(3, 32'h0, 4'hF); wr(7, 32'h0, 4'hF); wr(15, 32'h0, 4'hF);
        wr(6, 32'h1111_0001, 4'hF); wr(14, 32'h3333_0003, 4'hF);
        pulse(8'h0B);
        repeat (10) tick();
        check("rr_count", 64'(log_vec.size()), 64'd5);
        check("rr_first", {56'b0, log_vec[2]}, 64'd0);
        check("rr_second", {56'b0, log_vec[3]}, 64'd1);
        check("rr_third", {56'b0, log_vec[4]}, 64'd3);
        check("rr_data1", {32'b0, log_data[3]}, 64'h1111_0001);

        bus.msg_ready = 1'b0;
        pulse(8'h04);
        wait_valid(ok);
        check("stall_wait_valid", {63'b0, ok}, 64'h1);
        h_addr = bus.msg_addr; h_data = bus.msg_data; h_vec = bus.msg_vector;
        wr(10, 32'hDEAD_0002, 4'hF);
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", {63'b0, bus.msg_valid}, 64'h1);
            check("stall_addr", bus.msg_addr, h_addr);
            check("stall_data", {32'b0, bus.msg_data}, {32'b0, h_data});
            check("stall_vec", {56'b0, bus.msg_vector}, {56'b0, h_vec});
            tick();
        end
        bus.msg_ready = 1'b1;
        pulse(8'h04);
        repeat (6) tick();
        check("stall_count", 64'(log_vec.size()), 64'd7);
        check("stall_msg_data", {32'b0, log_data[5]}, 64'hABCD_0042);
        check("reraise_vec", {56'b0, log_vec[6]}, 64'd2);
        check("reraise_data", {32'b0, log_data[6]}, 64'hDEAD_0002);

        func_mask = 1'b1;
        pulse(8'h02);
        repeat (4) tick();
        check("fmask_count", 64'(log_vec.size()), 64'd7);
        rd(32, d); check("fmask_pba", {32'b0, d}, 64'h2);
        func_mask = 1'b0;
        repeat (5) tick();
        check("fmask_release_count", 64'(log_vec.size()), 64'd8);
        check("fmask_release_vec", {56'b0, log_vec[7]}, 64'd1);

        bus.msg_ready = 1'b0;
        pulse(8'h08);
        wait_valid(ok);
        check("rst_wait_valid", {63'b0, ok}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {63'b0, bus.msg_valid}, 64'h0);
        check("midrst_vec", {56'b0, bus.msg_vector}, 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        bus.msg_ready = 1'b1;
        rd(3, d);  check("post_rst_mask", {32'b0, d}, 64'h1);
        rd(10, d); check("post_rst_data", {32'b0, d}, 64'h0);
        rd(8, d);  check("post_rst_lo", {32'b0, d}, 64'h0);
        wr(32, 32'hFFFF_FFFF, 4'hF);
        rd(32, d); check("pba_write_ignored", {32'b0, d}, 64'h0);
        wr(40, 32'hFFFF_FFFF, 4'hF);
        rd(40, d); check("oor_read", {32'b0, d}, 64'h0);
        repeat (3) tick();
        check("post_rst_count", 64'(log_vec.size()), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/msix_vector_table.md
Name: msix_vector_table

Overview:
- Parametrised MSI-X capability backend: N-entry MSI-X table plus Pending Bit Array (PBA), with message generation.
- Successor to the single message-data register: holds per-vector address, data and mask state.
- Latches interrupt requests as pending bits and emits one memory-write message descriptor per vector via valid/ready to the TLP transmit path.
- Sits between the config/BAR register decoder and the posted-request generator.

Parameters:
- NUM_VECTORS, 8, number of table entries (1..256).
- PBA_DW, ceil(NUM_VECTORS/32), derived: PBA dwords.
- AW, clog2(4*NUM_VECTORS+PBA_DW), derived: dword address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- reg_wr_en  in  1  register write strobe
- reg_rd_en  in  1  register read strobe
- reg_addr  in  AW  dword address
- reg_wdata  in  32  write data
- reg_be  in  4  byte enables
- reg_rdata  out  32  read data
- reg_rd_valid  out  1  read data valid
- msix_enable  in  1  MSI-X Enable from capability
- func_mask  in  1  Function Mask from capability
- irq_req  in  NUM_VECTORS  per-vector one-cycle request pulses
- msg_valid  out  1  message descriptor valid
- msg_ready  in  1  downstream accepts
- msg_addr  out  64  message address
- msg_data  out  32  message data
- msg_vector  out  8  vector number

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Map: entry k occupies dwords 4k+0..4k+3: addr_lo, addr_hi, data, vector control (bit0 = mask, others read 0). PBA dword j at 4*NUM_VECTORS+j; bit i = pending of vector 32j+i.
- Reset: all addr/data = 0; all masks = 1; all pending = 0; FSM = IDLE.
- Outputs at reset: msg_valid = 0, msg_addr = 0, msg_data = 0, msg_vector = 0, reg_rdata = 0, reg_rd_valid = 0.
- Writes: per-byte via reg_be, effective next cycle. addr_lo[1:0] always stored as 0. PBA writes and out-of-range writes are ignored.
- Reads: 1-cycle latency; reg_rd_valid pulses one cycle after reg_rd_en. Out-of-range addresses read 0.
- Read and write to the same address in the same cycle: read returns the old value.
- Pending set: irq_req[k] sets pending[k]. A request on an already-pending vector is coalesced.
- Eligible[k] = pending[k] & ~mask[k] & msix_enable & ~func_mask.
- FSM IDLE:
  - If any vector is eligible, pick by round-robin starting after the last-sent vector (initial pointer: vector 0 first).
  - Capture {addr_hi,addr_lo}, data and k into the msg_* registers; assert msg_valid next cycle; go to SEND.
- FSM SEND:
  - Hold msg_valid and all msg_* fields stable until msg_ready.
  - On handshake: clear pending[k], update the RR pointer to k, go IDLE. Next message no earlier than the following cycle.
  - irq_req[k] in the same cycle as the handshake leaves pending[k] set (new event).
  - Mask, func_mask or table writes during SEND do not affect the captured descriptor; it completes.
- A masked vector retains pending. On unmask it becomes eligible and is sent.
- Clearing msix_enable: no new selections; pending bits are kept.
- Reset asserted mid-SEND: immediate return to reset state; descriptor dropped.
- Throughput: at most one message per 2 cycles (IDLE→SEND→IDLE).

Test Plan:
- Reset → read vector control dword 3 returns 0x00000001; PBA returns 0; msg_valid = 0.
- Write entry 2: addr_lo = 0xFEE0_0003 (BE=0xF), addr_hi = 0x1, data = 0xABCD_0042, then unmask; pulse irq_req[2] with msix_enable=1, msg_ready=1 → one message: addr 0x1_FEE0_0000, data 0xABCD_0042, vector 2; PBA bit2 clears.
- Vector 5 masked, irq_req[5] pulse → PBA reads 0x20, no message. Write mask = 0 → message vector 5 sent; PBA reads 0.
- Partial write BE=0x2, wdata=0x0000_5500 to data of entry 0 (old 0x1122_3344) → reads 0x1122_5544.
- irq_req = 0x0B simultaneously, msg_ready=1 → messages in order 0, 1, 3. Then msg_ready low 5 cycles on the next message → msg_valid and fields stable throughout.
- func_mask=1 with irq on vector 1 → no message, pending set. Deassert func_mask → message sent.
- Assert rst_n low mid-SEND → msg_valid drops immediately and all state returns to reset values.
